// File: rtl/implication_monitor.sv
// implication_monitor: synthesizable checker for "(a && b) |-> ##DELAY c".
// Each attempt is carried through a DELAY-deep pending pipeline together
// with its start cycle stamp. Outcomes become registered pass/fail pulses,
// saturating counters and a sticky first-fail capture.
// Optional build macro IMPLICATION_MONITOR_VACUOUS_EN adds vacuous_cnt.
// DELAY is meaningful in the range 1..16.
module implication_monitor #(
  parameter int DELAY = 1,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             clr,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_valid,
  output logic [TS_W-1:0]  first_fail_cycle
`ifdef IMPLICATION_MONITOR_VACUOUS_EN
  ,
  output logic [CNT_W-1:0] vacuous_cnt
`endif
);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic            ant;
  logic [TS_W-1:0] ts;
  logic            vld_p [DELAY];
  logic [TS_W-1:0] ts_p  [DELAY];
  logic            eval_due;
  logic [TS_W-1:0] eval_ts;

  assign ant      = a & b;
  assign eval_due = vld_p[DELAY-1];
  assign eval_ts  = ts_p[DELAY-1];

  // Free-running cycle stamp; clr deliberately leaves it running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 1'b1;
  end

  // Pending-attempt pipeline: stage 0 takes the new attempt, the last
  // stage is the one whose consequent is due this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        vld_p[i] <= 1'b0;
        ts_p[i]  <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < DELAY; i++) begin
        vld_p[i] <= 1'b0;
        ts_p[i]  <= '0;
      end
    end else begin
      vld_p[0] <= ant;
      ts_p[0]  <= ts;
      for (int i = 1; i < DELAY; i++) begin
        vld_p[i] <= vld_p[i-1];
        ts_p[i]  <= ts_p[i-1];
      end
    end
  end

  // Evaluation stage: c decides the due attempt; anything but a clean 1
  // (including X in simulation) falls into the fail branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_pulse       <= 1'b0;
      fail_pulse       <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
    end else if (clr) begin
      pass_pulse       <= 1'b0;
      fail_pulse       <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
    end else begin
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      if (eval_due) begin
        if (c) begin
          pass_pulse <= 1'b1;
          pass_cnt   <= sat_inc(pass_cnt);
        end else begin
          fail_pulse <= 1'b1;
          fail_cnt   <= sat_inc(fail_cnt);
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_cycle <= eval_ts;
          end
        end
      end
    end
  end

`ifdef IMPLICATION_MONITOR_VACUOUS_EN
  // Count edges with no antecedent and nothing due for evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     vacuous_cnt <= '0;
    else if (clr)                   vacuous_cnt <= '0;
    else if (!ant && !eval_due)     vacuous_cnt <= sat_inc(vacuous_cnt);
  end
`else
  // Without the vacuous counter there is no additional state.
`endif

endmodule
